// File: rtl/regfile_bist_initiator.sv
// regfile_bist_initiator: write/read-back self-test initiator for a latency-insensitive register file; BIST_INV_PASS_EN adds an inverted-pattern pass
module regfile_bist_initiator #(
    parameter int width = 32,
    parameter int n = 5,
    parameter int size = 32,
    parameter logic [width-1:0] seed = width'(32'hA5A5A5A5)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [n:0]       ERR_COUNT,
    output logic [n-1:0]     FIRST_FAIL_INDEX,
    output logic [n-1:0]     READ_REQ_WRITE,
    output logic             READ_REQ_WRITE_VALID,
    input  logic             READ_REQ_WRITE_CONSUMED,
    input  logic [width-1:0] READ_RESP_READ,
    input  logic             READ_RESP_READ_VALID,
    output logic             READ_RESP_READ_CONSUMED,
    output logic             WRITE_EN_WRITE,
    output logic             WRITE_EN_WRITE_VALID,
    input  logic             WRITE_EN_WRITE_CONSUMED,
    output logic [n-1:0]     WRITE_INDEX_WRITE,
    output logic             WRITE_INDEX_WRITE_VALID,
    input  logic             WRITE_INDEX_WRITE_CONSUMED,
    output logic [width-1:0] WRITE_DATA_WRITE,
    output logic             WRITE_DATA_WRITE_VALID,
    input  logic             WRITE_DATA_WRITE_CONSUMED
);

`ifdef BIST_INV_PASS_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_INV_WR, S_INV_RD, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;
`endif

    state_t state, state_n;
    logic [n:0] idx;
    logic [n:0] err_n;
    logic [2:0] wr_v, wr_f, wr_c, wr_fn;
    logic rq_v, rq_f, rs_f, rq_fn, rs_fn;
    logic wr_st, rd_st, inv, last, wr_done, rd_done, mis, start_ok;
    logic [width-1:0] pat, exp_d;

`ifdef BIST_INV_PASS_EN
    assign wr_st = state == S_WR || state == S_INV_WR;
    assign rd_st = state == S_RD || state == S_INV_RD;
    assign inv = state == S_INV_WR || state == S_INV_RD;
`else
    assign wr_st = state == S_WR;
    assign rd_st = state == S_RD;
    assign inv = 1'b0;
`endif

    // Beat bookkeeping: a beat finishes once every channel has been accepted, in any order
    always_comb begin
        pat = seed ^ width'(idx[n-1:0]);
        exp_d = inv ? ~pat : pat;
        wr_c = {WRITE_DATA_WRITE_CONSUMED, WRITE_INDEX_WRITE_CONSUMED, WRITE_EN_WRITE_CONSUMED};
        wr_fn = wr_f | (wr_v & wr_c);
        wr_done = wr_st && (&wr_fn);
        READ_RESP_READ_CONSUMED = rd_st && !rs_f && READ_RESP_READ_VALID;
        rq_fn = rq_f | (rq_v & READ_REQ_WRITE_CONSUMED);
        rs_fn = rs_f | READ_RESP_READ_CONSUMED;
        rd_done = rd_st && rq_fn && rs_fn;
        last = idx == (n+1)'(size - 1);
        mis = READ_RESP_READ_CONSUMED && READ_RESP_READ != exp_d;
        err_n = (mis && ERR_COUNT != '1) ? ERR_COUNT + 1'b1 : ERR_COUNT;
        start_ok = START && (state == S_IDLE || state == S_DONE);
    end

    // Next-state logic; START is only honoured while idle or finished
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: if (START) state_n = S_WR;
            S_WR:           if (wr_done && last) state_n = S_RD;
`ifdef BIST_INV_PASS_EN
            S_RD:           if (rd_done && last) state_n = S_INV_WR;
            S_INV_WR:       if (wr_done && last) state_n = S_INV_RD;
            S_INV_RD:       if (rd_done && last) state_n = S_DONE;
`else
            S_RD:           if (rd_done && last) state_n = S_DONE;
`endif
            default:        state_n = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else state <= state_n;
    end

    // Handshake flags, index and result registers; an all-clear beat relaunches one cycle later
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx <= '0;
            wr_v <= '0;
            wr_f <= '0;
            rq_v <= 1'b0;
            rq_f <= 1'b0;
            rs_f <= 1'b0;
            ERR_COUNT <= '0;
            FIRST_FAIL_INDEX <= '0;
            PASS <= 1'b0;
        end else if (start_ok) begin
            idx <= '0;
            ERR_COUNT <= '0;
            FIRST_FAIL_INDEX <= '0;
            PASS <= 1'b0;
        end else begin
            if (wr_st) begin
                wr_v <= (wr_v == '0 && wr_f == '0) ? 3'b111 : wr_v & ~wr_c;
                wr_f <= wr_done ? '0 : wr_fn;
            end
            if (rd_st) begin
                rq_v <= (!rq_v && !rq_f) ? 1'b1 : rq_v & ~READ_REQ_WRITE_CONSUMED;
                rq_f <= rd_done ? 1'b0 : rq_fn;
                rs_f <= rd_done ? 1'b0 : rs_fn;
            end
            if (wr_done || rd_done) idx <= last ? '0 : idx + 1'b1;
            ERR_COUNT <= err_n;
            if (mis && ERR_COUNT == '0) FIRST_FAIL_INDEX <= idx[n-1:0];
            if (state_n == S_DONE && state != S_DONE) PASS <= err_n == '0;
        end
    end

    assign BUSY = state != S_IDLE && state != S_DONE;
    assign DONE = state == S_DONE;
    assign READ_REQ_WRITE = idx[n-1:0];
    assign READ_REQ_WRITE_VALID = rq_v;
    assign WRITE_EN_WRITE = 1'b1;
    assign WRITE_EN_WRITE_VALID = wr_v[0];
    assign WRITE_INDEX_WRITE = idx[n-1:0];
    assign WRITE_INDEX_WRITE_VALID = wr_v[1];
    assign WRITE_DATA_WRITE = exp_d;
    assign WRITE_DATA_WRITE_VALID = wr_v[2];

endmodule
